// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: the icache request/response pair plus the
// instruction hand-off to the decoder. The fetch queue is the master.
interface inst_fetch_queue_if;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_inst;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_ready_in;

    modport master (
        output ic_req_valid,
        output ic_req_addr,
        input  ic_resp_valid,
        input  ic_resp_inst,
        output inst_valid_out,
        output inst_out,
        output pc_out,
        input  inst_ready_in
    );

    modport slave (
        input  ic_req_valid,
        input  ic_req_addr,
        output ic_resp_valid,
        output ic_resp_inst,
        input  inst_valid_out,
        input  inst_out,
        input  pc_out,
        output inst_ready_in
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: generates sequential fetch PCs, keeps at most
// one icache request in flight, buffers returned words with their PCs
// and presents the oldest {inst, pc} to the decoder. A flush empties the
// queue and restarts fetch at a new PC; a response still in flight when
// the flush lands is dropped on arrival.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | no icache request outstanding
//   S_WAIT    | one request outstanding, its word will be queued
//   S_DISCARD | one request outstanding, its word will be dropped
module inst_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic [31:0]         flush_pc_in,
    inst_fetch_queue_if.master  bus,
    output logic                full_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [31:0]        fetch_pc;
    logic [31:0]        inst_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               req_valid;
    logic               head_valid;
    logic               enq;
    logic               deq;

    // A request only goes out when a slot is free, so the slot is
    // effectively reserved and an enqueue can never meet a full queue.
    assign req_valid  = (state == S_IDLE) && (count < DEPTH_CNT) && rdy_in && !flush_in;
    assign head_valid = (count != '0) && rdy_in;

    assign bus.ic_req_valid   = req_valid;
    assign bus.ic_req_addr    = fetch_pc;
    assign bus.inst_valid_out = head_valid;
    assign bus.inst_out       = inst_mem[head];
    assign bus.pc_out         = pc_mem[head];
    assign full_out           = (count == DEPTH_CNT);

    // Queue movement for this cycle; a flush suppresses both directions.
    always_comb begin
        enq = 1'b0;
        deq = 1'b0;
        if (!flush_in) begin
            enq = (state == S_WAIT) && bus.ic_resp_valid;
            deq = head_valid && bus.inst_ready_in;
        end
    end

    // Next-state logic for the request tracker.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // A response arriving here has no owner and is ignored.
                if (req_valid) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_in) begin
                    // Response in the flush cycle is simply dropped; otherwise
                    // remember that the late response belongs to the old path.
                    state_nxt = bus.ic_resp_valid ? S_IDLE : S_DISCARD;
                end else if (bus.ic_resp_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!flush_in && bus.ic_resp_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC: redirect on flush, advance when a word is accepted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc <= RESET_PC;
        end else if (flush_in) begin
            fetch_pc <= flush_pc_in;
        end else if (enq) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared at reset so the head outputs read zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (enq) begin
            inst_mem[tail] <= bus.ic_resp_inst;
            pc_mem[tail]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: reset check, a hand-computed vector table
// for flush/pause corners, directed fill/drain/wrap sequences, then
// randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;
    localparam int DEPTH = 8;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        full;

    inst_fetch_queue_if bus();

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .rdy_in      (rdy),
        .flush_in    (flush),
        .flush_pc_in (flush_pc),
        .bus         (bus),
        .full_out    (full)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: FIFO of {inst, pc}, next fetch address, whether a
    // request is in flight and whether its answer belongs to a dead path.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_stale;

    function automatic void m_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_out   = 1'b0;
        m_stale = 1'b0;
    endfunction

    // Behavioural icache and observation logs.
    bit          auto_ic = 1'b0;
    bit          use_model = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;
    int          lat_max = 0;
    logic [31:0] req_log[$];
    logic [31:0] deq_pc[$];
    logic [31:0] deq_inst[$];

    // One clock: drive icache response, compare at negedge, advance model.
    task automatic cycle();
        bit e_req;
        bit e_iv;
        bit resp;
        bit rd;
        logic [31:0] rinst;
        if (auto_ic) begin
            if (pend && pend_wait == 0) begin
                bus.ic_resp_valid = 1'b1;
                bus.ic_resp_inst  = pend_addr ^ 32'hA5A5_A5A5;
                pend = 1'b0;
            end else begin
                bus.ic_resp_valid = 1'b0;
                if (pend) pend_wait--;
            end
        end
        @(negedge clk);
        resp  = bus.ic_resp_valid;
        rinst = bus.ic_resp_inst;
        rd    = bus.inst_ready_in;
        e_req = !m_out && (mq.size() < DEPTH) && rdy && !flush;
        e_iv  = (mq.size() != 0) && rdy;
        if (use_model) begin
            chk("req_valid", 32'(bus.ic_req_valid), 32'(e_req));
            if (e_req) chk("req_addr", bus.ic_req_addr, m_pc);
            chk("inst_valid", 32'(bus.inst_valid_out), 32'(e_iv));
            if (e_iv) begin
                chk("pc_out", bus.pc_out, mq[0][31:0]);
                chk("inst_out", bus.inst_out, mq[0][63:32]);
            end
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
        end
        if (bus.ic_req_valid) req_log.push_back(bus.ic_req_addr);
        if (bus.inst_valid_out && rd && !flush) begin
            deq_pc.push_back(bus.pc_out);
            deq_inst.push_back(bus.inst_out);
        end
        if (flush) begin
            mq.delete();
            m_pc = flush_pc;
            if (m_out && !m_stale) begin
                if (resp) m_out = 1'b0;
                else      m_stale = 1'b1;
            end
        end else begin
            if (e_iv && rd) void'(mq.pop_front());
            if (m_out && resp) begin
                if (!m_stale) begin
                    mq.push_back({rinst, m_pc});
                    m_pc = m_pc + 32'd4;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (e_req) m_out = 1'b1;
        end
        if (auto_ic && bus.ic_req_valid) begin
            pend      = 1'b1;
            pend_addr = bus.ic_req_addr;
            pend_wait = $urandom_range(lat_max, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        flush = 1'b0;
        rdy = 1'b0;
        bus.inst_ready_in = 1'b0;
        bus.ic_resp_valid = 1'b0;
        pend = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          flush;
        logic [31:0] fpc;
        bit          resp;
        logic [31:0] rinst;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          e_full;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit hold;
        int guard;
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_inst  = 32'h0;
        bus.inst_ready_in = 1'b0;
        m_reset();

        // Hand-computed sequence: fetch, flush while waiting (late word
        // dropped), flush coinciding with a response, pause with a response
        // pending, stray response in idle.
        tbl[0]  = '{T, F, 32'h0,   F, 32'h0,         F, T, 32'h0,   F, 32'h0,   32'h0,         F};
        tbl[1]  = '{T, F, 32'h0,   T, 32'hA5A5A5A5,  F, F, 32'h0,   F, 32'h0,   32'h0,         F};
        tbl[2]  = '{T, F, 32'h0,   F, 32'h0,         F, T, 32'h4,   T, 32'h0,   32'hA5A5A5A5,  F};
        tbl[3]  = '{T, T, 32'h100, F, 32'h0,         F, F, 32'h4,   T, 32'h0,   32'hA5A5A5A5,  F};
        tbl[4]  = '{T, F, 32'h0,   F, 32'h0,         F, F, 32'h100, F, 32'h0,   32'h0,         F};
        tbl[5]  = '{T, F, 32'h0,   T, 32'hDEADBEEF,  F, F, 32'h100, F, 32'h0,   32'h0,         F};
        tbl[6]  = '{T, F, 32'h0,   F, 32'h0,         F, T, 32'h100, F, 32'h0,   32'h0,         F};
        tbl[7]  = '{T, F, 32'h0,   T, 32'hA5A5A4A5,  F, F, 32'h100, F, 32'h0,   32'h0,         F};
        tbl[8]  = '{T, F, 32'h0,   F, 32'h0,         T, T, 32'h104, T, 32'h100, 32'hA5A5A4A5,  F};
        tbl[9]  = '{T, T, 32'h200, T, 32'h12345678,  F, F, 32'h104, F, 32'h0,   32'h0,         F};
        tbl[10] = '{T, F, 32'h0,   F, 32'h0,         F, T, 32'h200, F, 32'h0,   32'h0,         F};
        tbl[11] = '{F, F, 32'h0,   T, 32'hA5A5A7A5,  F, F, 32'h200, F, 32'h0,   32'h0,         F};
        tbl[12] = '{F, F, 32'h0,   T, 32'h55555555,  F, F, 32'h204, F, 32'h0,   32'h0,         F};
        tbl[13] = '{T, F, 32'h0,   F, 32'h0,         T, T, 32'h204, T, 32'h200, 32'hA5A5A7A5,  F};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(bus.ic_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid_out), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_inst_out", bus.inst_out, 32'h0);
        chk("rst_pc_out", bus.pc_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            rdy               = tbl[i].rdy;
            flush             = tbl[i].flush;
            flush_pc          = tbl[i].fpc;
            bus.ic_resp_valid = tbl[i].resp;
            bus.ic_resp_inst  = tbl[i].rinst;
            bus.inst_ready_in = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), 32'(bus.ic_req_valid), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i), bus.ic_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_iv", i), 32'(bus.inst_valid_out), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_pc", i), bus.pc_out, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), bus.inst_out, tbl[i].e_inst);
            end
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        bus.ic_resp_valid = 1'b0;

        // Fill with 1-cycle icache and no consumer, then drain.
        do_reset();
        auto_ic = 1'b1;
        use_model = 1'b1;
        lat_max = 0;
        rdy = 1'b1;
        req_log.delete();
        repeat (24) cycle();
        chk("fill_req_count", 32'(req_log.size()), 32'd8);
        for (int i = 0; i < req_log.size() && i < 8; i++)
            chk("fill_req_addr", req_log[i], 32'(i * 4));
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_no_req", 32'(bus.ic_req_valid), 32'h0);

        bus.inst_ready_in = 1'b1;
        deq_pc.delete();
        deq_inst.delete();
        repeat (30) cycle();
        chk("drain_resumed", 32'(deq_pc.size() > 8), 32'h1);
        for (int i = 0; i < deq_pc.size(); i++) begin
            chk("drain_pc", deq_pc[i], 32'(i * 4));
            chk("drain_inst", deq_inst[i], 32'(i * 4) ^ 32'hA5A5_A5A5);
        end

        // Seven entries, simultaneous enqueue and dequeue, tail wrap.
        do_reset();
        rdy = 1'b1;
        guard = 0;
        while (!(mq.size() == 7 && m_out) && guard < 40) begin
            cycle();
            guard++;
        end
        chk("count7_reached", 32'(guard < 40), 32'h1);
        bus.inst_ready_in = 1'b1;
        cycle();
        bus.inst_ready_in = 1'b0;
        chk("enqdeq_full", 32'(full), 32'h0);
        chk("enqdeq_head_pc", bus.pc_out, 32'h4);
        guard = 0;
        while (!full && guard < 10) begin
            cycle();
            guard++;
        end
        chk("wrap_full", 32'(full), 32'h1);
        bus.inst_ready_in = 1'b1;
        deq_pc.delete();
        deq_inst.delete();
        repeat (20) cycle();
        chk("wrap_drained", 32'(deq_pc.size() >= 8), 32'h1);
        for (int i = 0; i < deq_pc.size(); i++)
            chk("wrap_pc", deq_pc[i], 32'(4 + i * 4));

        // Pause with three entries and a response pending.
        do_reset();
        rdy = 1'b1;
        guard = 0;
        while (!(mq.size() == 3 && m_out) && guard < 40) begin
            cycle();
            guard++;
        end
        chk("count3_reached", 32'(guard < 40), 32'h1);
        rdy = 1'b0;
        repeat (5) cycle();
        chk("pause_iv", 32'(bus.inst_valid_out), 32'h0);
        chk("pause_req", 32'(bus.ic_req_valid), 32'h0);
        rdy = 1'b1;
        bus.inst_ready_in = 1'b1;
        #1;
        chk("resume_iv", 32'(bus.inst_valid_out), 32'h1);
        chk("resume_pc", bus.pc_out, 32'h0);
        deq_pc.delete();
        deq_inst.delete();
        repeat (12) cycle();
        chk("resume_count", 32'(deq_pc.size() >= 4), 32'h1);
        for (int i = 0; i < deq_pc.size(); i++)
            chk("resume_seq", deq_pc[i], 32'(i * 4));

        // Randomized traffic with flushes, pauses and occasional resets.
        do_reset();
        lat_max = 3;
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                rst_n = 1'b1;
                hold = 1'b1;
            end
            if (hold && !pend) hold = 1'b0;
            rdy = hold ? 1'b0 : ($urandom_range(9, 0) != 0);
            bus.inst_ready_in = $urandom_range(1, 0) == 1;
            flush = ($urandom_range(29, 0) == 0) && !(m_stale && pend && pend_wait == 0);
            flush_pc = $urandom() & 32'hFFFF_FFFC;
            cycle();
        end
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
